// File: rtl/imem_wb_loader.sv
// -----------------------------------------------------------------------------
// imem_wb_loader
//
// Wishbone classic slave that gives firmware load/readback access to the
// instruction SRAM through its read/write port 0, and owns the core hold line
// so that a program can be loaded while the core is frozen.
//
// The block decodes one 4 KB page:
//   0x000-0x7FC  imem window, one 32-bit word per address (word = adr[10:2])
//   0x800        CTRL   bit0 = hold (reset 1), other bits read 0
//   0x804        WCOUNT number of committed imem writes, saturating;
//                read-only, any write clears it
//   other        acked, reads 0, writes ignored
//
// Ports
//   wb_clk_i, wb_rst_i      clock (shared with SRAM clk0), synchronous
//                           active-high reset
//   wbs_*                   Wishbone classic slave port
//   mem_*0_*                SRAM port 0 (csb/web active low)
//   core_hold_o             1 = core held
//
// Parameters
//   BASE_ADDR  page base, bits [11:0] must be zero
//   WCOUNT_W   width of the write counter (1..32), read back zero-extended
// -----------------------------------------------------------------------------
module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WCOUNT_W  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,

    output logic        mem_csb0_o,
    output logic        mem_web0_o,
    output logic [3:0]  mem_wmask0_o,
    output logic [8:0]  mem_addr0_o,
    output logic [31:0] mem_din0_o,
    input  logic [31:0] mem_dout0_i,

    output logic        core_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDWAIT,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        K_IMEM,
        K_CTRL,
        K_WCOUNT,
        K_NONE
    } kind_t;

    localparam logic [WCOUNT_W-1:0] WCOUNT_MAX = '1;

    state_t              state_reg, state_next;
    logic [8:0]          addr_reg;
    logic [31:0]         din_reg;
    logic [3:0]          sel_reg;
    logic                hold_reg;
    logic                hold_out_reg;
    logic [WCOUNT_W-1:0] wcount_reg;
    logic [31:0]         dat_reg;

    logic  page_hit;
    logic  req;
    kind_t req_kind;

    // Byte lane bits of the address carry no information for word accesses.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    always_comb begin
        page_hit = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
        req      = wbs_cyc_i & wbs_stb_i & page_hit;
        req_kind = K_NONE;
        if (!wbs_adr_i[11]) begin
            req_kind = K_IMEM;
        end else if (wbs_adr_i[10:2] == 9'h000) begin
            req_kind = K_CTRL;
        end else if (wbs_adr_i[10:2] == 9'h001) begin
            req_kind = K_WCOUNT;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    if (req_kind == K_IMEM) begin
                        if (!wbs_we_i) begin
                            state_next = S_READ;
                        end else if (hold_reg && (wbs_sel_i != 4'b0000)) begin
                            state_next = S_WRITE;
                        end else begin
                            // Write while the core runs (or with no lanes)
                            // is acked but never reaches the SRAM.
                            state_next = S_ACK;
                        end
                    end else begin
                        state_next = S_ACK;
                    end
                end
            end
            S_WRITE:  state_next = S_ACK;
            S_READ:   state_next = S_RDWAIT;
            S_RDWAIT: state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            din_reg      <= '0;
            sel_reg      <= '0;
            hold_reg     <= 1'b1;
            hold_out_reg <= 1'b1;
            wcount_reg   <= '0;
            dat_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            // The core sees a hold change one cycle after the register
            // changes, i.e. the cycle following the ack.
            hold_out_reg <= hold_reg;

            if ((state_reg == S_IDLE) && req) begin
                case (req_kind)
                    K_IMEM: begin
                        addr_reg <= wbs_adr_i[10:2];
                        din_reg  <= wbs_dat_i;
                        sel_reg  <= wbs_sel_i;
                    end
                    K_CTRL: begin
                        if (wbs_we_i) begin
                            hold_reg <= wbs_dat_i[0];
                        end else begin
                            dat_reg <= {31'b0, hold_reg};
                        end
                    end
                    K_WCOUNT: begin
                        if (wbs_we_i) begin
                            wcount_reg <= '0;
                        end else begin
                            dat_reg <= 32'(wcount_reg);
                        end
                    end
                    default: begin
                        if (!wbs_we_i) begin
                            dat_reg <= '0;
                        end
                    end
                endcase
            end

            // The FSM is single-issue, so a clear and an increment can never
            // coincide here.
            if ((state_reg == S_WRITE) && (wcount_reg != WCOUNT_MAX)) begin
                wcount_reg <= wcount_reg + 1'b1;
            end

            if (state_reg == S_RDWAIT) begin
                dat_reg <= mem_dout0_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_csb0_o   = !((state_reg == S_WRITE) || (state_reg == S_READ));
    assign mem_web0_o   = (state_reg != S_WRITE);
    assign mem_wmask0_o = (state_reg == S_WRITE) ? sel_reg : 4'b0000;
    assign mem_addr0_o  = addr_reg;
    assign mem_din0_o   = din_reg;

    // An abandoned cycle (cyc/stb dropped) passes through ACK silently.
    assign wbs_ack_o    = (state_reg == S_ACK) && wbs_cyc_i && wbs_stb_i;
    assign wbs_dat_o    = dat_reg;
    assign core_hold_o  = hold_out_reg;

endmodule

// File: tb/tb_imem_wb_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_wb_loader
//
// Directed bench for imem_wb_loader with a behavioural model of SRAM port 0.
// The counter width is reduced so saturation is reached in a short run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_wb_loader;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int          WCW      = 6;
    localparam logic [31:0] WCNT_MAX = 32'd63;

    logic        clk;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mem_csb0_o, mem_web0_o;
    logic [3:0]  mem_wmask0_o;
    logic [8:0]  mem_addr0_o;
    logic [31:0] mem_din0_o;
    logic [31:0] mem_dout0_i;
    logic        core_hold_o;

    imem_wb_loader #(
        .BASE_ADDR (BASE),
        .WCOUNT_W  (WCW)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .mem_csb0_o   (mem_csb0_o),
        .mem_web0_o   (mem_web0_o),
        .mem_wmask0_o (mem_wmask0_o),
        .mem_addr0_o  (mem_addr0_o),
        .mem_din0_o   (mem_din0_o),
        .mem_dout0_i  (mem_dout0_i),
        .core_hold_o  (core_hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM port 0 model: synchronous, byte-masked write, registered read.
    logic [31:0] sram [512];
    always @(posedge clk) begin
        if (!mem_csb0_o) begin
            if (!mem_web0_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask0_o[b]) sram[mem_addr0_o][8*b +: 8] <= mem_din0_o[8*b +: 8];
                end
            end else begin
                mem_dout0_i <= sram[mem_addr0_o];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Values captured by wb_xfer for the caller.
    logic        c1_csb, c1_web;
    logic [8:0]  c1_addr;
    logic [3:0]  c1_wmask;
    logic        csb_low_seen;
    logic        ack_hold;

    // One Wishbone transfer; call at posedge+1. Cycle 0 is the cycle in which
    // the request is presented. ack_cyc = -1 if no ack within limit cycles.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int limit,
                           output logic [31:0] rdata, output int ack_cyc);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        ack_cyc = -1; rdata = 32'h0; csb_low_seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!mem_csb0_o) csb_low_seen = 1'b1;
            if (n == 1) begin
                c1_csb = mem_csb0_o; c1_web = mem_web0_o;
                c1_addr = mem_addr0_o; c1_wmask = mem_wmask0_o;
            end
            if (wbs_ack_o) begin
                ack_cyc = n; rdata = wbs_dat_o; ack_hold = core_hold_o;
                break;
            end
        end
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        $display("xfer we=%0b adr=%08h sel=%h dat=%08h -> ack_cyc=%0d rdata=%08h",
                 we, adr, sel, dat, ack_cyc, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int          ac;
    int          acks;

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_hold",  32'(core_hold_o), 32'd1);
        check_eq("rst_csb",   32'(mem_csb0_o),  32'd1);
        check_eq("rst_web",   32'(mem_web0_o),  32'd1);
        check_eq("rst_ack",   32'(wbs_ack_o),   32'd0);
        check_eq("rst_dat",   wbs_dat_o,        32'd0);
        check_eq("rst_wmask", 32'(mem_wmask0_o), 32'd0);
        check_eq("rst_addr",  32'(mem_addr0_o), 32'd0);
        @(posedge clk); #1;
        wb_xfer(1'b0, BASE + 32'h800, 4'hF, 32'h0, 8, rd, ac);
        check_eq("ctrl_rst_ack", ac, 1);
        check_eq("ctrl_rst_val", rd, 32'h1);
        wb_xfer(1'b0, BASE + 32'h804, 4'hF, 32'h0, 8, rd, ac);
        check_eq("wcnt_rst_ack", ac, 1);
        check_eq("wcnt_rst_val", rd, 32'h0);

        // Reset in the middle of an imem read
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h010; wbs_sel_i = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check_eq("midrst_read_strobe", 32'(mem_csb0_o), 32'd0);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        @(negedge clk);
        check_eq("midrst_csb", 32'(mem_csb0_o), 32'd1);
        check_eq("midrst_ack", 32'(wbs_ack_o),  32'd0);
        @(posedge clk); #1;

        // Word write then read
        wb_xfer(1'b1, BASE + 32'h010, 4'hF, 32'hDEADBEEF, 8, rd, ac);
        check_eq("w1_ack_cyc", ac, 2);
        check_eq("w1_c1_csb",  32'(c1_csb),   32'd0);
        check_eq("w1_c1_web",  32'(c1_web),   32'd0);
        check_eq("w1_c1_addr", 32'(c1_addr),  32'd4);
        check_eq("w1_c1_mask", 32'(c1_wmask), 32'hF);
        wb_xfer(1'b0, BASE + 32'h804, 4'hF, 32'h0, 8, rd, ac);
        check_eq("wcnt_after_w1", rd, 32'd1);
        wb_xfer(1'b0, BASE + 32'h010, 4'hF, 32'h0, 8, rd, ac);
        check_eq("r1_ack_cyc", ac, 3);
        check_eq("r1_data",    rd, 32'hDEADBEEF);
        check_eq("r1_c1_web",  32'(c1_web), 32'd1);

        // Byte write into a preloaded word
        wb_xfer(1'b1, BASE + 32'h014, 4'hF, 32'h11223344, 8, rd, ac);
        wb_xfer(1'b1, BASE + 32'h014, 4'b0010, 32'hAABBCCDD, 8, rd, ac);
        check_eq("bw_ack_cyc", ac, 2);
        check_eq("bw_mask",    32'(c1_wmask), 32'h2);
        wb_xfer(1'b0, BASE + 32'h014, 4'hF, 32'h0, 8, rd, ac);
        check_eq("bw_readback", rd, 32'h1122CC44);

        // Write with no byte lanes is dropped even while held
        wb_xfer(1'b1, BASE + 32'h018, 4'h0, 32'h12345678, 8, rd, ac);
        check_eq("sel0_ack_cyc", ac, 1);
        check_eq("sel0_no_sram", 32'(csb_low_seen), 32'd0);

        // Unmapped in-page and out-of-page
        wb_xfer(1'b0, BASE + 32'hC00, 4'hF, 32'h0, 8, rd, ac);
        check_eq("unmap_ack_cyc", ac, 1);
        check_eq("unmap_data",    rd, 32'h0);
        wb_xfer(1'b1, BASE + 32'hC00, 4'hF, 32'hFFFF_FFFF, 8, rd, ac);
        check_eq("unmap_wr_ack", ac, 1);
        wb_xfer(1'b0, BASE + 32'h1000, 4'hF, 32'h0, 10, rd, ac);
        check_eq("offpage_noack", ac, -1);

        // Abort during RDWAIT
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h010; wbs_sel_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        check_eq("abort_noack", acks, 0);
        @(posedge clk); #1;
        wb_xfer(1'b0, BASE + 32'h800, 4'hF, 32'h0, 8, rd, ac);
        check_eq("abort_idle_ack", ac, 1);

        // Release hold
        wb_xfer(1'b1, BASE + 32'h800, 4'hF, 32'h0, 8, rd, ac);
        check_eq("unhold_ack_cyc",  ac, 1);
        check_eq("unhold_during_ack", 32'(ack_hold), 32'd1);
        @(negedge clk);
        check_eq("unhold_after_ack", 32'(core_hold_o), 32'd0);
        @(posedge clk); #1;
        wb_xfer(1'b0, BASE + 32'h800, 4'hF, 32'h0, 8, rd, ac);
        check_eq("ctrl_unheld", rd, 32'h0);

        // Imem write while running is dropped
        wb_xfer(1'b1, BASE + 32'h010, 4'hF, 32'h0BAD0BAD, 8, rd, ac);
        check_eq("prot_ack_cyc", ac, 1);
        check_eq("prot_no_sram", 32'(csb_low_seen), 32'd0);
        wb_xfer(1'b0, BASE + 32'h804, 4'hF, 32'h0, 8, rd, ac);
        check_eq("prot_wcnt", rd, 32'd3);
        wb_xfer(1'b0, BASE + 32'h010, 4'hF, 32'h0, 8, rd, ac);
        check_eq("prot_read_ok", rd, 32'hDEADBEEF);

        // Re-hold, saturate the counter (3 + 62 = 65 writes), then clear
        wb_xfer(1'b1, BASE + 32'h800, 4'hF, 32'h1, 8, rd, ac);
        for (int i = 0; i < 62; i++) begin
            wb_xfer(1'b1, BASE + 32'(4 * (i + 16)), 4'hF, 32'(i), 8, rd, ac);
        end
        wb_xfer(1'b0, BASE + 32'h804, 4'hF, 32'h0, 8, rd, ac);
        check_eq("wcnt_saturated", rd, WCNT_MAX);
        wb_xfer(1'b1, BASE + 32'h804, 4'hF, 32'h1234, 8, rd, ac);
        check_eq("wcnt_clr_ack", ac, 1);
        wb_xfer(1'b0, BASE + 32'h804, 4'hF, 32'h0, 8, rd, ac);
        check_eq("wcnt_cleared", rd, 32'h0);
        wb_xfer(1'b0, BASE + 32'(4 * 20), 4'hF, 32'h0, 8, rd, ac);
        check_eq("loop_word_readback", rd, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_wb_loader.md
# imem_wb_loader

Wishbone slave that loads and reads back the instruction SRAM through its read/write port 0, replacing logic-analyser bit-banging of that port. It sits between the Caravel Wishbone bus and the `sky130_sram_2kbyte_1rw1r_32x512_8` port 0, while the core keeps port 1 for fetch. It also owns the core hold line, so firmware can freeze the core, load a program and then release it.

## Interface
- BASE_ADDR, 32'h3000_0000, base of the 4 KB Wishbone page decoded by the block (bits [11:0] must be 0)
- wb_clk_i  in  1  single clock; the SRAM clk0 is on the same net
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- mem_csb0_o  out  1  SRAM port-0 chip select, active low
- mem_web0_o  out  1  SRAM port-0 write enable, active low
- mem_wmask0_o  out  4  SRAM byte write mask
- mem_addr0_o  out  9  SRAM word address
- mem_din0_o  out  32  SRAM write data
- mem_dout0_i  in  32  SRAM port-0 read data
- core_hold_o  out  1  1 = core held (fetch stalled / reset)

## Operation
- Page hit: wbs_adr_i[31:12] == BASE_ADDR[31:12]. Requests outside the page are never acked.
- Page map:
  - 0x000–0x7FC: imem window, word index = adr[10:2].
  - 0x800: CTRL, R/W, bit0 = hold, reset value 1, other bits read 0.
  - 0x804: WCOUNT, 16-bit, read-only; any write clears it to 0.
  - Any other in-page offset: ack, read 0, write ignored.
- FSM states: IDLE, WRITE, READ, RDWAIT, ACK.
  - IDLE: on cyc&stb&hit, latch adr[10:2], dat_i, sel and we.
    - Imem write with hold=1 and sel≠0 → WRITE.
    - Imem write with hold=0 or sel=0 → ACK; write dropped, no SRAM cycle, counter unchanged.
    - Imem read → READ (allowed regardless of hold).
    - Register or unmapped access → ACK; register effect applied on entry to ACK.
  - WRITE: csb0=0, web0=0, wmask0=latched sel, addr0 and din0 latched; WCOUNT += 1, saturating at 0xFFFF; → ACK.
  - READ: csb0=0, web0=1, wmask0=0; → RDWAIT.
  - RDWAIT: capture mem_dout0_i into the read-data register; → ACK.
  - ACK: if cyc&stb is still high, wbs_ack_o=1 for this cycle only; otherwise no ack (aborted cycle). Always → IDLE.
- mem_csb0_o is 1 in every state except WRITE and READ; web0 is 1 outside WRITE.
- A committed SRAM write is never cancelled by an abort.
- wbs_dat_o holds its last value between acks; it is driven only at ACK.
- Clearing hold takes effect on core_hold_o the cycle after the ack.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0
  - mem_csb0_o=1, mem_web0_o=1, mem_wmask0_o=0, mem_addr0_o=0, mem_din0_o=0
  - core_hold_o=1, WCOUNT=0, state IDLE
- Reset mid-transaction: the next cycle is IDLE with csb0=1 and no ack.
- Latency (cycle 0 = request sampled in IDLE):
  - Imem write: ack in cycle 2.
  - Imem read: ack in cycle 3; SRAM strobed in cycle 1, dout0 sampled at the end of cycle 2.
  - Register, unmapped or dropped write: ack in cycle 1.
- Back-to-back: the next request is accepted only in IDLE, so at least one idle cycle follows each ack. The master must drop stb after sampling ack.
- Simultaneous WCOUNT clear and increment cannot occur: the FSM is single-issue.

## Test plan
- Reset: after wb_rst_i, core_hold_o=1, csb0=1, web0=1, ack=0, CTRL reads 0x1, WCOUNT reads 0.
- Word write then read, using the SRAM behavioural model:
  - Write 0xDEADBEEF to BASE+0x010, sel=4'hF → cycle 1: csb0=0, web0=0, addr0=9'd4, wmask0=4'hF; ack in cycle 2; WCOUNT=1.
  - Read BASE+0x010 → ack in cycle 3 with 0xDEADBEEF.
- Byte write:
  - Preload 0x11223344 at word 5.
  - Write 0xAABBCCDD, sel=4'b0010 → wmask0=4'b0010; readback = 0x1122CC44.
- Hold protection:
  - Write 0 to BASE+0x800 → core_hold_o falls the cycle after the ack.
  - Imem write → ack in cycle 1, csb0 stays 1, WCOUNT unchanged.
- Abort and unmapped:
  - Drop cyc during RDWAIT → no ack, FSM returns to IDLE.
  - Read BASE+0xC00 → ack in cycle 1 with 0x0.
  - Access BASE+0x1000 → no ack for 10 cycles.
- Saturation and clear:
  - Issue 65 537 writes → WCOUNT = 0xFFFF.
  - Write to BASE+0x804 → reads back 0.
